// File: rtl/lion_mem_pkg.sv
// lion_mem_pkg: shared types and constants for the Lion memory responder.
package lion_mem_pkg;
  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} memresp_state_t;

  // Request as captured in IDLE and held for the whole transaction
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              instr;
  } mem_req_t;

  // Byte offset from the window base, wrapping modulo 2^32
  function automatic logic [WORD_W-1:0] word_offset(input logic [WORD_W-1:0] addr,
                                                    input logic [WORD_W-1:0] base);
    return addr - base;
  endfunction
endpackage

// File: rtl/lion_mem_array.sv
// lion_mem_array: single-port RAM built from independent byte lanes.
// Synchronous per-lane write, asynchronous read of the addressed word.
module lion_mem_array
  import lion_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [STRB_W-1:0]     i_we,
  input  logic [WORD_W-1:0]     i_wdata,
  output logic [WORD_W-1:0]     o_rdata
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  for (genvar g = 0; g < STRB_W; g++) begin : g_lane
    logic [7:0] r_lane [0:DEPTH-1];

    // Write this byte lane when its enable is set; contents are never reset
    always_ff @(posedge clock) begin
      if (i_we[g]) r_lane[i_addr] <= i_wdata[8*g +: 8];
    end

    assign o_rdata[8*g +: 8] = r_lane[i_addr];
  end
endmodule

// File: rtl/lion_mem_responder.sv
// lion_mem_responder: word-addressed memory model for the Lion native port.
// Answers each request after LATENCY wait states with a one-cycle ready,
// returning the pre-write word and applying byte-strobed writes.
// Optional feature: define LION_MEMRESP_BOUNDS_EN to add mem_fault and
// reject accesses outside the RAM window instead of aliasing them.
module lion_mem_responder
  import lion_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_ready,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              busy,
  output logic              proto_err
`ifdef LION_MEMRESP_BOUNDS_EN
  ,
  output logic              mem_fault
`endif
);
  memresp_state_t        r_state;
  logic [LAT_W-1:0]      r_cnt;
  mem_req_t              r_req;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_ready;
  logic [WORD_W-1:0]     r_rdata;
  logic                  r_busy;
  logic                  r_perr;

  logic [WORD_W-1:0]     w_offset;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [WORD_W-1:0]     w_ram_rd;
  logic [STRB_W-1:0]     w_we;
  logic                  w_viol;
  logic                  w_unused;

  assign w_offset = word_offset(mem_addr, BASE_ADDR);
  assign w_idx    = w_offset[DEPTH_LOG2+1:2];

  // Initiator dropped or altered the request while it is outstanding
  assign w_viol = !mem_valid
               || (mem_addr  != r_req.addr)
               || (mem_wdata != r_req.wdata)
               || (mem_wstrb != r_req.wstrb);

`ifdef LION_MEMRESP_BOUNDS_EN
  logic r_oor;
  logic r_fault;
  logic w_oor;

  assign w_oor = |w_offset[WORD_W-1:DEPTH_LOG2+2];

  // Out-of-range flag is latched with the request
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_oor   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      if (r_state == IDLE && mem_valid) r_oor <= w_oor;
      if (r_state == WAIT && r_cnt == '0) r_fault <= r_oor;
    end
  end

  assign mem_fault = r_fault;
  // Write lands at the end of RESP unless reset hits that edge or it is out of range
  assign w_we = (r_state == RESP && reset && !r_oor) ? r_req.wstrb : '0;
`else
  assign w_we = (r_state == RESP && reset) ? r_req.wstrb : '0;
`endif

  lion_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clock   (clock),
    .i_addr  (r_idx),
    .i_we    (w_we),
    .i_wdata (r_req.wdata),
    .o_rdata (w_ram_rd)
  );

  // Request FSM with registered ready/rdata/busy and sticky protocol flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (mem_valid) begin
            r_req   <= '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, instr: mem_instr};
            r_idx   <= w_idx;
            r_cnt   <= LAT_W'(LATENCY);
            r_busy  <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
            r_ready <= 1'b1;
`ifdef LION_MEMRESP_BOUNDS_EN
            r_rdata <= r_oor ? '0 : w_ram_rd;
`else
            r_rdata <= w_ram_rd;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (r_state != IDLE && w_viol) r_perr <= 1'b1;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign busy      = r_busy;
  assign proto_err = r_perr;

  // Fetch tag and sub-word / high offset bits carry no function here
  assign w_unused = &{1'b0, r_req.instr, w_offset[1:0], w_offset[WORD_W-1:DEPTH_LOG2+2]};
endmodule

// File: tb/tb_lion_mem_responder.sv
// Directed bench for lion_mem_responder: three instances (LATENCY 1/0/15).
module tb_lion_mem_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]        v = '0;
  logic              instr = 1'b0;
  logic [31:0]       addr = '0, wdata = '0;
  logic [3:0]        wstrb = '0;
  logic [2:0]        rdy, bsy, perr, flt;
  logic [2:0][31:0]  rdat;
  int n_pass = 0, n_tot = 0;

  lion_mem_responder #(.DEPTH_LOG2(4), .LATENCY(1), .BASE_ADDR(32'h0)) u_main (
    .clock(clock), .reset(reset), .mem_valid(v[0]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[0]), .mem_rdata(rdat[0]),
    .busy(bsy[0]), .proto_err(perr[0])
`ifdef LION_MEMRESP_BOUNDS_EN
    , .mem_fault(flt[0])
`endif
  );
  lion_mem_responder #(.DEPTH_LOG2(10), .LATENCY(0), .BASE_ADDR(32'h0)) u_lat0 (
    .clock(clock), .reset(reset), .mem_valid(v[1]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[1]), .mem_rdata(rdat[1]),
    .busy(bsy[1]), .proto_err(perr[1])
`ifdef LION_MEMRESP_BOUNDS_EN
    , .mem_fault(flt[1])
`endif
  );
  lion_mem_responder #(.DEPTH_LOG2(10), .LATENCY(15), .BASE_ADDR(32'h0)) u_lat15 (
    .clock(clock), .reset(reset), .mem_valid(v[2]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[2]), .mem_rdata(rdat[2]),
    .busy(bsy[2]), .proto_err(perr[2])
`ifdef LION_MEMRESP_BOUNDS_EN
    , .mem_fault(flt[2])
`endif
  );
`ifndef LION_MEMRESP_BOUNDS_EN
  assign flt = '0;
`endif

  // One request: cycle 0 is the first valid cycle; cyc is the ready cycle (-1 on timeout)
  task automatic do_req(input int sel, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output int cyc, output logic [31:0] rd,
                        output logic bz_ok, output logic fl);
    @(negedge clock);
    addr = a; wdata = wd; wstrb = ws; v[sel] = 1'b1;
    cyc = -1; rd = '0; bz_ok = 1'b1; fl = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (!bsy[sel]) bz_ok = 1'b0;
      if (rdy[sel]) begin cyc = k; rd = rdat[sel]; fl = flt[sel]; break; end
    end
    @(posedge clock); #1;
    v[sel] = 1'b0;
    @(negedge clock);
    if (bsy[sel]) bz_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; v = '0;
    repeat (3) @(negedge clock);
    n_tot++; if (rdy[0] !== 1'b0) $display("FAIL reset_ready got=%b exp=0", rdy[0]); else n_pass++;
    n_tot++; if (rdat[0] !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdat[0]); else n_pass++;
    n_tot++; if (bsy[0] !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bsy[0]); else n_pass++;
    n_tot++; if (perr[0] !== 1'b0) $display("FAIL reset_perr got=%b exp=0", perr[0]); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    int cyc; logic [31:0] rd; logic bz, fl;
    do_req(0, 32'h10, 32'hDEADBEEF, 4'hF, cyc, rd, bz, fl);
    n_tot++; if (cyc !== 3) $display("FAIL wr_ready_cycle got=%0d exp=3", cyc); else n_pass++;
    n_tot++; if (bz !== 1'b1) $display("FAIL wr_busy got=%b exp=1", bz); else n_pass++;
    do_req(0, 32'h10, 32'h0, 4'h0, cyc, rd, bz, fl);
    n_tot++; if (cyc !== 3) $display("FAIL rd_ready_cycle got=%0d exp=3", cyc); else n_pass++;
    n_tot++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", rd); else n_pass++;
    n_tot++; if (perr[0] !== 1'b0) $display("FAIL rd_perr got=%b exp=0", perr[0]); else n_pass++;
  endtask

  task automatic test_partial();
    int cyc; logic [31:0] rd; logic bz, fl;
    do_req(0, 32'h20, 32'h11223344, 4'hF, cyc, rd, bz, fl);
    do_req(0, 32'h20, 32'hAABBCCDD, 4'b0101, cyc, rd, bz, fl);
    n_tot++; if (rd !== 32'h11223344) $display("FAIL partial_old got=%h exp=11223344", rd); else n_pass++;
    do_req(0, 32'h20, 32'h0, 4'h0, cyc, rd, bz, fl);
    n_tot++; if (rd !== 32'h11BB33DD) $display("FAIL partial_new got=%h exp=11bb33dd", rd); else n_pass++;
  endtask

  task automatic test_latency();
    int cyc; logic [31:0] rd; logic bz, fl;
    do_req(1, 32'h100, 32'h0, 4'h0, cyc, rd, bz, fl);
    n_tot++; if (cyc !== 2) $display("FAIL lat0_cycle got=%0d exp=2", cyc); else n_pass++;
    n_tot++; if (bz !== 1'b1) $display("FAIL lat0_busy got=%b exp=1", bz); else n_pass++;
    do_req(2, 32'h100, 32'h0, 4'h0, cyc, rd, bz, fl);
    n_tot++; if (cyc !== 17) $display("FAIL lat15_cycle got=%0d exp=17", cyc); else n_pass++;
    n_tot++; if (bz !== 1'b1) $display("FAIL lat15_busy got=%b exp=1", bz); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c1, c2; logic [31:0] d1, d2;
    c1 = -1; c2 = -1; d1 = '0; d2 = '0;
    @(negedge clock);
    addr = 32'h10; wdata = 32'h0; wstrb = 4'h0; v[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (rdy[0]) begin
        if (c1 < 0) begin
          c1 = k; d1 = rdat[0];
          @(posedge clock); #1;
          addr = 32'h20;
        end else begin
          c2 = k; d2 = rdat[0];
          break;
        end
      end
    end
    @(posedge clock); #1;
    v[0] = 1'b0;
    n_tot++; if (c1 !== 3) $display("FAIL b2b_first_cycle got=%0d exp=3", c1); else n_pass++;
    n_tot++; if (c2 !== 7) $display("FAIL b2b_second_cycle got=%0d exp=7", c2); else n_pass++;
    n_tot++; if (d1 !== 32'hDEADBEEF) $display("FAIL b2b_first_data got=%h exp=deadbeef", d1); else n_pass++;
    n_tot++; if (d2 !== 32'h11BB33DD) $display("FAIL b2b_second_data got=%h exp=11bb33dd", d2); else n_pass++;
    n_tot++; if (perr[0] !== 1'b0) $display("FAIL b2b_perr got=%b exp=0", perr[0]); else n_pass++;
  endtask

  task automatic test_proto();
    int cyc; logic [31:0] rd; logic bz, fl;
    do_req(2, 32'h40, 32'h0BADF00D, 4'hF, cyc, rd, bz, fl);
    do_req(2, 32'h44, 32'h12345678, 4'hF, cyc, rd, bz, fl);
    n_tot++; if (perr[2] !== 1'b0) $display("FAIL proto_clean got=%b exp=0", perr[2]); else n_pass++;
    @(negedge clock);
    addr = 32'h40; wdata = 32'h0; wstrb = 4'h0; v[2] = 1'b1;
    repeat (3) @(negedge clock);
    addr = 32'h44;
    cyc = -1; rd = '0;
    for (int k = 4; k <= 40; k++) begin
      @(negedge clock);
      if (rdy[2]) begin cyc = k; rd = rdat[2]; break; end
    end
    @(posedge clock); #1;
    v[2] = 1'b0;
    n_tot++; if (cyc !== 17) $display("FAIL proto_cycle got=%0d exp=17", cyc); else n_pass++;
    n_tot++; if (rd !== 32'h0BADF00D) $display("FAIL proto_data got=%h exp=0badf00d", rd); else n_pass++;
    repeat (3) @(negedge clock);
    n_tot++; if (perr[2] !== 1'b1) $display("FAIL proto_sticky got=%b exp=1", perr[2]); else n_pass++;
    n_tot++; if (perr[0] !== 1'b0) $display("FAIL proto_other got=%b exp=0", perr[0]); else n_pass++;
  endtask

  task automatic test_reset_resp();
    int cyc; logic [31:0] rd; logic bz, fl; logic got, late;
    do_req(0, 32'h08, 32'h55AA55AA, 4'hF, cyc, rd, bz, fl);
    @(negedge clock);
    addr = 32'h08; wdata = 32'h0; wstrb = 4'hF; v[0] = 1'b1;
    got = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (rdy[0]) begin got = 1'b1; break; end
    end
    reset = 1'b0; v[0] = 1'b0;
    @(negedge clock);
    n_tot++; if (got !== 1'b1) $display("FAIL rstresp_reached got=%b exp=1", got); else n_pass++;
    n_tot++; if ({rdy[0], bsy[0], perr[0]} !== 3'b000) $display("FAIL rstresp_flags got=%b exp=000", {rdy[0], bsy[0], perr[0]}); else n_pass++;
    n_tot++; if (rdat[0] !== 32'h0) $display("FAIL rstresp_rdata got=%h exp=0", rdat[0]); else n_pass++;
    reset = 1'b1;
    late = 1'b0;
    repeat (6) begin @(negedge clock); if (rdy[0]) late = 1'b1; end
    n_tot++; if (late !== 1'b0) $display("FAIL rstresp_late_ready got=%b exp=0", late); else n_pass++;
    do_req(0, 32'h08, 32'h0, 4'h0, cyc, rd, bz, fl);
    n_tot++; if (rd !== 32'h55AA55AA) $display("FAIL rstresp_old got=%h exp=55aa55aa", rd); else n_pass++;
  endtask

  task automatic test_bounds();
    int cyc; logic [31:0] rd; logic bz, fl;
    do_req(0, 32'h00, 32'hCAFE0001, 4'hF, cyc, rd, bz, fl);
    do_req(0, 32'h40, 32'hFFFFFFFF, 4'hF, cyc, rd, bz, fl);
`ifdef LION_MEMRESP_BOUNDS_EN
    n_tot++; if (fl !== 1'b1) $display("FAIL oob_fault got=%b exp=1", fl); else n_pass++;
    n_tot++; if (rd !== 32'h0) $display("FAIL oob_rdata got=%h exp=0", rd); else n_pass++;
    do_req(0, 32'h00, 32'h0, 4'h0, cyc, rd, bz, fl);
    n_tot++; if (rd !== 32'hCAFE0001) $display("FAIL oob_word0 got=%h exp=cafe0001", rd); else n_pass++;
    n_tot++; if (fl !== 1'b0) $display("FAIL inb_fault got=%b exp=0", fl); else n_pass++;
`else
    n_tot++; if (rd !== 32'hCAFE0001) $display("FAIL alias_old got=%h exp=cafe0001", rd); else n_pass++;
    do_req(0, 32'h00, 32'h0, 4'h0, cyc, rd, bz, fl);
    n_tot++; if (rd !== 32'hFFFFFFFF) $display("FAIL alias_word0 got=%h exp=ffffffff", rd); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_latency();
    test_back_to_back();
    test_proto();
    test_reset_resp();
    test_bounds();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_tot);
    $fatal(1);
  end
endmodule

// File: doc/lion_mem_responder.md
# lion_mem_responder

Word-addressed memory responder for the Lion core's native memory port: it answers `mem_valid` requests with a registered `mem_ready` / `mem_rdata` after a programmable number of wait states. It applies byte-strobed writes to an internal RAM. It replaces free-running random read data in simulation and bounded-proof harnesses, and sits beside `LionFV` inside the harness wrapper. It also flags requests that the initiator changes while they are pending.

## Interface

Parameters:
- `DEPTH_LOG2`, 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, 1: wait states per request, legal range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address that maps to word 0.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-low; reset takes effect when `reset`==0 at a rising edge.
- `mem_valid`  in  1: request pending, held by the core until `mem_ready`.
- `mem_instr`  in  1: request is an instruction fetch; informational only.
- `mem_addr`  in  32: byte address.
- `mem_wdata`  in  32: write data.
- `mem_wstrb`  in  4: byte write enables; 0 means read.
- `mem_ready`  out  1: one-cycle completion pulse.
- `mem_rdata`  out  32: read data, valid only while `mem_ready`==1.
- `busy`  out  1: a request is accepted and not yet completed.
- `proto_err`  out  1: sticky protocol-violation flag.
- `mem_fault`  out  1: present only with `LION_MEMRESP_BOUNDS_EN`; asserts with `mem_ready` for an out-of-range access.

## Operation

- FSM states:
  - IDLE: `busy`=0. When `mem_valid`=1, capture `mem_addr`, `mem_wdata`, `mem_wstrb` and `mem_instr`, load `cnt`=LATENCY, then go to WAIT.
  - WAIT: `busy`=1. If `cnt`==0, go to RESP; otherwise decrement `cnt`.
  - RESP: `mem_ready`=1 and `mem_rdata`=RAM[idx] (pre-write contents). Apply the write for each lane i with `wstrb[i]`=1. Return to IDLE.
- Index: `idx` = ((addr − BASE_ADDR) >> 2) truncated to DEPTH_LOG2 bits; modulo-2^32 subtraction. `addr[1:0]` is ignored, so misaligned addresses act on the containing word.
- Read-modify-write: `mem_rdata` returned with a write is the old word. Lanes with `wstrb`=0 keep their contents.
- Protocol check in WAIT and RESP:
  - `proto_err` sets if `mem_valid`=0.
  - `proto_err` sets if any of `mem_addr`, `mem_wdata`, `mem_wstrb` differs from the captured value.
  - The captured request is still served unchanged.
- Cycle after RESP: FSM is in IDLE. If `mem_valid` is still 1, it is treated as a new request.
- Reset: FSM→IDLE, `cnt`=0, `mem_ready`=0, `mem_rdata`=0, `busy`=0, `proto_err`=0, `mem_fault`=0.
  - RAM contents are not reset.
  - Reset during WAIT or RESP aborts the request; no write occurs if reset is asserted in the RESP cycle.

## Timing

- With the first `mem_valid` cycle as cycle 0: WAIT starts at cycle 1, `mem_ready` pulses at cycle LATENCY+2.
- LATENCY=0 gives a ready in cycle 2; back-to-back requests complete every LATENCY+3 cycles.
- All outputs are registered; there is no combinational path from inputs to `mem_ready` or `mem_rdata`.
- A write is visible to a read served in any later RESP cycle.

## Configuration

- `LION_MEMRESP_BOUNDS_EN` defined:
  - The `mem_fault` port exists.
  - An access with (addr − BASE_ADDR) ≥ 4·2^DEPTH_LOG2 is out of range. It returns `mem_rdata`=0, suppresses the write, and asserts `mem_fault` with `mem_ready`.
- Macro undefined: there is no `mem_fault` port, and out-of-range addresses alias modulo the RAM size.

## Structure

- `lion_mem_pkg` holds:
  - the FSM state enum `memresp_state_t` (IDLE, WAIT, RESP);
  - `LAT_W`=4;
  - the word and strobe width constants.
- Sub-module `lion_mem_array`:
  - single-port byte-lane RAM, DEPTH_LOG2 deep;
  - synchronous write with a 4-bit lane enable;
  - asynchronous read port used by RESP.

## Test plan

- LATENCY=1: write 0xDEADBEEF with strobe 0xF to 0x10, then read 0x10 → ready at cycle 3 each, rdata=0xDEADBEEF, `proto_err`=0.
- Partial write: preload 0x11223344 at 0x20, write 0xAABBCCDD with strobe 0b0101, then read → 0x11BB33DD; the write cycle's rdata is 0x11223344.
- LATENCY=0 and LATENCY=15: a single read gives ready at cycle 2 and cycle 17 respectively; `busy` is high from cycle 1 through the ready cycle.
- `mem_addr` changed from 0x40 to 0x44 during WAIT → `proto_err`=1 (stays high until reset) and data comes from 0x40.
- Reset asserted in the RESP cycle of a write to 0x08 → no ready after reset, all outputs 0, and a later read of 0x08 returns the old value.
- With `LION_MEMRESP_BOUNDS_EN`, DEPTH_LOG2=4: write to 0x40 → `mem_fault`=1, and a read of 0x00 is unchanged. Without the macro, the same write aliases to word 0.
